// File: rtl/plot_receiver.sv
// plot_receiver: buffers pixel writes from a drawing datapath into a small
// first-word-fall-through FIFO in front of a framebuffer write port.
// Stage 1 registers the pixel and its linear address, stage 2 pushes it into
// the FIFO, and the FIFO head drives the framebuffer port directly.
// Optional feature macro: PLOT_RECEIVER_CLIP_EN discards off-screen pixels
// at stage 2 and counts them in clip_count.
module plot_receiver #(
  parameter int RES_X = 160,
  parameter int RES_Y = 120,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        plot,
  input  logic [8:0]  x,
  input  logic [8:0]  y,
  input  logic [2:0]  color,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  input  logic        mem_ready,
  output logic [4:0]  fifo_level,
  output logic        overflow,
  output logic [15:0] clip_count,
  output logic        busy
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 1: pixel register
  // ---------------------------------------------------------------------------
  logic        s1_valid;
  logic [14:0] s1_addr;
  logic [2:0]  s1_color;
  logic [14:0] addr_calc;

  // All operands are 15 bits wide so the sum wraps modulo 2^15, which is the
  // same as computing the full address and keeping the low 15 bits.
  assign addr_calc = 15'(y) * 15'(RES_X) + 15'(x);

`ifdef PLOT_RECEIVER_CLIP_EN
  logic s1_clip;
  logic off_screen;

  assign off_screen = (32'(x) >= 32'(RES_X)) || (32'(y) >= 32'(RES_Y));

  // Capture the off-screen decision alongside the pixel; it is acted on in stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_clip <= 1'b0;
    end else begin
      s1_clip <= off_screen;
    end
  end
`endif

  // Register the incoming pixel; plot during reset is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_color <= '0;
    end else begin
      s1_valid <= plot;
      s1_addr  <= addr_calc;
      s1_color <= color;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: push decision
  // ---------------------------------------------------------------------------
  logic push_req;

`ifdef PLOT_RECEIVER_CLIP_EN
  assign push_req = s1_valid && !s1_clip;
`else
  assign push_req = s1_valid;
`endif

  // ---------------------------------------------------------------------------
  // FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  logic [14:0]      fifo_addr  [DEPTH];
  logic [2:0]       fifo_color [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [4:0]       level;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;

  assign empty = (level == '0);
  assign full  = (level == DEPTH_L);
  assign pop   = !empty && mem_ready;
  // When full, a simultaneous pop frees the slot the push writes into.
  assign push  = push_req && (!full || pop);

  // Entry storage; no reset needed because outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr]  <= s1_addr;
      fifo_color[wr_ptr] <= s1_color;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Clip counter
  // ---------------------------------------------------------------------------
`ifdef PLOT_RECEIVER_CLIP_EN
  logic [15:0] clip_cnt;

  // Count discarded off-screen pixels, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      clip_cnt <= '0;
    end else if (s1_valid && s1_clip && (clip_cnt != '1)) begin
      clip_cnt <= clip_cnt + 1'b1;
    end
  end

  assign clip_count = clip_cnt;
`else
  assign clip_count = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Head entry drives the port; forced to zero when empty so the port reads 0
  // out of reset and never exposes stale storage.
  always_comb begin
    mem_addr = '0;
    mem_data = '0;
    if (!empty) begin
      mem_addr = fifo_addr[rd_ptr];
      mem_data = fifo_color[rd_ptr];
    end
  end

  assign mem_we     = !empty;
  assign fifo_level = level;
  assign busy       = s1_valid || !empty;

endmodule

// File: tb/tb_plot_receiver.sv
// Testbench for plot_receiver: queue-based reference model checked every
// cycle, plus directed scenarios for latency, backpressure, overflow, reset,
// clipping and a full-screen sweep.
module tb_plot_receiver;

  localparam int RES_X = 160;
  localparam int RES_Y = 120;
  localparam int DEPTH = 8;
`ifdef PLOT_RECEIVER_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        plot = 1'b0;
  logic [8:0]  x = '0;
  logic [8:0]  y = '0;
  logic [2:0]  color = '0;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic [15:0] clip_count;
  logic        busy;

  plot_receiver #(.RES_X(RES_X), .RES_Y(RES_Y), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .plot(plot), .x(x), .y(y), .color(color),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .fifo_level(fifo_level), .overflow(overflow),
    .clip_count(clip_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pending pixel in flight plus a queue of accepted pixels.
  typedef struct {
    logic [14:0] a;
    logic [2:0]  c;
  } ent_t;

  ent_t q[$];
  bit   s_v = 1'b0;
  bit   s_clip = 1'b0;
  ent_t s_e;
  bit   m_ovf = 1'b0;
  int   m_clip = 0;

  logic [14:0] wr_log[$];

  // One clock cycle: drive inputs, check outputs against the model, clock,
  // then advance the model by one cycle. Returns 1 time unit after the edge.
  task automatic step(input bit p, input int xi, input int yi, input bit [2:0] ci,
                      input bit rdy, input bit rst);
    bit pop_m;
    bit full_m;
    plot      = p;
    x         = 9'(xi);
    y         = 9'(yi);
    color     = ci;
    mem_ready = rdy;
    reset     = rst;

    check("mem_we", 32'(mem_we), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check("mem_addr", 32'(mem_addr), 32'(q[0].a));
      check("mem_data", 32'(mem_data), 32'(q[0].c));
    end
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("busy", 32'(busy), 32'(s_v || (q.size() != 0)));
    check("clip_count", 32'(clip_count), 32'(m_clip));

    if (mem_we && mem_ready) wr_log.push_back(mem_addr);

    @(posedge clk);

    if (rst) begin
      q.delete();
      s_v    = 1'b0;
      s_clip = 1'b0;
      m_ovf  = 1'b0;
      m_clip = 0;
    end else begin
      full_m = (q.size() == DEPTH);
      pop_m  = (q.size() != 0) && rdy;
      if (pop_m) void'(q.pop_front());
      if (s_v) begin
        if (CLIP_EN && s_clip) begin
          if (m_clip < 65535) m_clip++;
        end else if (full_m && !pop_m) begin
          m_ovf = 1'b1;
        end else begin
          q.push_back(s_e);
        end
      end
      s_v    = p;
      s_e.a  = 15'((yi * RES_X + xi) % 32768);
      s_e.c  = ci;
      s_clip = (xi >= RES_X) || (yi >= RES_Y);
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 3'd0, rdy, 1'b0);
  endtask

  initial begin
    int bad;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 3'd0, 1'b1, 1'b1);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_clip", 32'(clip_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_data", 32'(mem_data), 0);

    // Single pixel: write appears two cycles after plot, for one cycle
    step(1'b1, 3, 2, 3'd5, 1'b1, 1'b0);
    check("single_lat1_we", 32'(mem_we), 0);
    step(1'b0, 0, 0, 3'd0, 1'b1, 1'b0);
    check("single_we", 32'(mem_we), 1);
    check("single_addr", 32'(mem_addr), 323);
    check("single_data", 32'(mem_data), 5);
    step(1'b0, 0, 0, 3'd0, 1'b1, 1'b0);
    check("single_done", 32'(mem_we), 0);

    // Backpressure: 8 plots fill the FIFO, the 9th overflows
    for (int i = 0; i < 8; i++)
      step(1'b1, $urandom_range(0, RES_X - 1), $urandom_range(0, RES_Y - 1),
           3'($urandom), 1'b0, 1'b0);
    step(1'b0, 0, 0, 3'd0, 1'b0, 1'b0);
    check("bp_level8", 32'(fifo_level), 8);
    check("bp_no_ovf", 32'(overflow), 0);
    // Stable head while stalled
    check("bp_stable_addr", 32'(mem_addr), 32'(q[0].a));
    step(1'b1, 10, 10, 3'd7, 1'b0, 1'b0);
    step(1'b0, 0, 0, 3'd0, 1'b0, 1'b0);
    check("bp_ovf", 32'(overflow), 1);
    check("bp_level_kept", 32'(fifo_level), 8);
    wr_log.delete();
    idle(10, 1'b1);
    check("bp_drain_cnt", 32'(wr_log.size()), 8);
    check("bp_ovf_sticky", 32'(overflow), 1);

    // Full with simultaneous push and pop
    step(1'b0, 0, 0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++)
      step(1'b1, $urandom_range(0, RES_X - 1), $urandom_range(0, RES_Y - 1),
           3'($urandom), 1'b0, 1'b0);
    check("full_level", 32'(fifo_level), 8);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, $urandom_range(0, RES_X - 1), $urandom_range(0, RES_Y - 1),
           3'($urandom), 1'b1, 1'b0);
      check("full_pp_level", 32'(fifo_level), 8);
      check("full_pp_ovf", 32'(overflow), 0);
    end
    idle(12, 1'b1);

    // Reset mid-stream, with plot asserted during the reset cycle
    for (int i = 0; i < 5; i++)
      step(1'b1, $urandom_range(0, RES_X - 1), $urandom_range(0, RES_Y - 1),
           3'($urandom), 1'b0, 1'b0);
    step(1'b0, 0, 0, 3'd0, 1'b0, 1'b0);
    check("mid_level5", 32'(fifo_level), 5);
    step(1'b1, 1, 1, 3'd1, 1'b0, 1'b1);
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_we", 32'(mem_we), 0);
    check("mid_rst_busy", 32'(busy), 0);
    step(1'b1, 7, 1, 3'd6, 1'b1, 1'b0);
    step(1'b0, 0, 0, 3'd0, 1'b1, 1'b0);
    check("mid_after_we", 32'(mem_we), 1);
    check("mid_after_addr", 32'(mem_addr), 167);
    idle(3, 1'b1);

    // Clip boundary
    wr_log.delete();
    step(1'b1, 160, 0, 3'd2, 1'b1, 1'b0);
    step(1'b1, 159, 119, 3'd3, 1'b1, 1'b0);
    idle(4, 1'b1);
    if (CLIP_EN) begin
      check("clip_count1", 32'(clip_count), 1);
      check("clip_writes", 32'(wr_log.size()), 1);
      if (wr_log.size() > 0) check("clip_addr", 32'(wr_log[0]), 19199);
    end else begin
      check("noclip_count", 32'(clip_count), 0);
      check("noclip_writes", 32'(wr_log.size()), 2);
      if (wr_log.size() > 1) begin
        check("noclip_addr0", 32'(wr_log[0]), 160);
        check("noclip_addr1", 32'(wr_log[1]), 19199);
      end
    end

    // Randomized traffic, including off-screen coordinates and occasional reset
    for (int i = 0; i < 3000; i++) begin
      int xi;
      int yi;
      xi = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, RES_X + 5);
      yi = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, RES_Y + 5);
      step(1'($urandom_range(0, 3) != 0), xi, yi, 3'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 299) == 0));
    end
    idle(12, 1'b1);

    // Full-screen raster sweep
    step(1'b0, 0, 0, 3'd0, 1'b1, 1'b1);
    wr_log.delete();
    for (int yy = 0; yy < RES_Y; yy++)
      for (int xx = 0; xx < RES_X; xx++)
        step(1'b1, xx, yy, 3'($urandom), 1'b1, 1'b0);
    idle(4, 1'b1);
    check("sweep_cnt", 32'(wr_log.size()), RES_X * RES_Y);
    bad = 0;
    foreach (wr_log[i]) if (32'(wr_log[i]) != 32'(i)) bad++;
    check("sweep_order_bad", 32'(bad), 0);
    check("sweep_ovf", 32'(overflow), 0);
    check("sweep_idle_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
